// File: rtl/led_pattern_ctrl_if.sv
// Button/LED bundle between the raw board pins and the LED pattern engine.
interface led_pattern_ctrl_if #(
  parameter int unsigned NUM_LEDS = 4
);
  logic [3:0]          i_Btn;
  logic [NUM_LEDS-1:0] o_LED;
  logic [1:0]          o_Mode;

  modport master (output i_Btn, input o_LED, input o_Mode);
  modport slave  (input i_Btn, output o_LED, output o_Mode);
endinterface

// File: rtl/led_pattern_ctrl.sv
// Debounced four-button mode selector driving STATIC/CHASE/BOUNCE/BLINK LED patterns.
// Press events win over same-cycle step ticks; the lowest button index wins among presses.
module led_pattern_ctrl #(
  parameter int unsigned NUM_LEDS      = 4,
  parameter int unsigned CLKS_PER_STEP = 6250000,
  parameter int unsigned DEBOUNCE_CLKS = 250000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  led_pattern_ctrl_if.slave bus
);
  localparam int unsigned NUM_BTNS = 4;
  localparam int unsigned STEP_W   = $clog2(CLKS_PER_STEP);
  localparam int unsigned DB_W     = $clog2(DEBOUNCE_CLKS);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(CLKS_PER_STEP - 1);
  localparam logic [DB_W-1:0]     DB_LAST   = DB_W'(DEBOUNCE_CLKS - 1);
  localparam logic [NUM_LEDS-1:0] LED_BIT0  = NUM_LEDS'(1);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  logic [NUM_BTNS-1:0]           sync1_q, sync2_q, db_q, db_d, db_prev_q;
  logic [NUM_BTNS-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [NUM_BTNS-1:0]           press_c;
  logic                          press_vld_c;
  logic [1:0]                    press_idx_c;

  mode_e               mode_q, mode_d;
  logic [NUM_LEDS-1:0] led_q, led_d, led_rotl_c, shifted_c;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic                dir_left_q, dir_left_d;
  logic                step_c;

  // Input path: 2-flop synchroniser plus per-button debounce state
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      db_cnt_q  <= '0;
    end else begin
      sync1_q   <= bus.i_Btn;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      db_cnt_q  <= db_cnt_d;
    end
  end

  always_comb begin
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < NUM_BTNS; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_d[i]     = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  assign press_c = db_q & ~db_prev_q;

  // Lowest-index press wins
  always_comb begin
    press_vld_c = 1'b0;
    press_idx_c = 2'd0;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (press_c[i]) begin
        press_vld_c = 1'b1;
        press_idx_c = 2'(i);
      end
    end
  end

  // Mode state register
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) mode_q <= MODE_STATIC;
    else          mode_q <= mode_d;
  end

  // Mode next-state
  always_comb begin
    mode_d = mode_q;
    if (press_vld_c) mode_d = mode_e'(press_idx_c);
  end

  assign led_rotl_c = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
  assign step_c     = (mode_q != MODE_STATIC) && (step_cnt_q == STEP_LAST);

  // Pattern, step counter and bounce direction next-state
  always_comb begin
    led_d      = led_q;
    step_cnt_d = step_cnt_q;
    dir_left_d = dir_left_q;
    shifted_c  = dir_left_q ? (led_q << 1) : (led_q >> 1);
    if (press_vld_c) begin
      if ((press_idx_c == MODE_STATIC) && (mode_q == MODE_STATIC)) begin
        led_d = led_rotl_c;
      end else begin
        led_d      = (press_idx_c == MODE_BLINK) ? '1 : LED_BIT0;
        step_cnt_d = '0;
        dir_left_d = 1'b1;
      end
    end else if (mode_q != MODE_STATIC) begin
      step_cnt_d = step_c ? '0 : step_cnt_q + STEP_W'(1);
      if (step_c) begin
        case (mode_q)
          MODE_CHASE: led_d = led_rotl_c;
          MODE_BOUNCE: begin
            led_d = shifted_c;
            if (dir_left_q && shifted_c[NUM_LEDS-1]) dir_left_d = 1'b0;
            if (!dir_left_q && shifted_c[0])         dir_left_d = 1'b1;
          end
          MODE_BLINK: led_d = ~led_q;
          default:    led_d = led_q;
        endcase
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      led_q      <= LED_BIT0;
      step_cnt_q <= '0;
      dir_left_q <= 1'b1;
    end else begin
      led_q      <= led_d;
      step_cnt_q <= step_cnt_d;
      dir_left_q <= dir_left_d;
    end
  end

  assign bus.o_LED  = led_q;
  assign bus.o_Mode = mode_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl: expectations are queued with their due cycle
// when stimulus is driven and compared on the falling edge of that cycle.
module tb_led_pattern_ctrl;
  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int          n_assert;
  int          n_fail;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  led;
    logic [1:0]  mode;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  led_pattern_ctrl_if #(.NUM_LEDS(4)) bus_if ();

  led_pattern_ctrl #(
    .NUM_LEDS     (4),
    .CLKS_PER_STEP(4),
    .DEBOUNCE_CLKS(3)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_L(rst_n),
    .bus    (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_at(input int unsigned c, input logic [3:0] led,
                           input logic [1:0] mode, input string tag);
    exp_t e;
    e.cyc  = c;
    e.led  = led;
    e.mode = mode;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Compare every expectation due this cycle; anything overdue is reported
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        check_val({exp_q[i].tag, "_led"},  32'(bus_if.o_LED),  32'(exp_q[i].led));
        check_val({exp_q[i].tag, "_mode"}, 32'(bus_if.o_Mode), 32'(exp_q[i].mode));
        exp_q.delete(i);
      end else if (exp_q[i].cyc < cyc) begin
        check_val({exp_q[i].tag, "_late"}, cyc, exp_q[i].cyc);
        exp_q.delete(i);
      end
    end
  end

  initial begin
    int unsigned t, e, p, q, s, u;
    logic [3:0] rot_exp [4];
    logic [3:0] prev_exp [4];
    rot_exp  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    prev_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    n_assert     = 0;
    n_fail       = 0;
    cyc          = 0;
    bus_if.i_Btn = 4'b0000;
    rst_n        = 1'b1;

    // Power-on reset values
    #1 rst_n = 1'b0;
    #1;
    check_val("por_led",  32'(bus_if.o_LED),  32'h1);
    check_val("por_mode", 32'(bus_if.o_Mode), 32'h0);
    tick(3);
    rst_n = 1'b1;
    t = cyc;
    expect_at(t + 2, 4'b0001, 2'd0, "idle");
    tick(4);

    // CHASE entry latency and rotation
    bus_if.i_Btn[1] = 1'b1;
    t = cyc;
    e = t + 6;
    expect_at(e - 1,  4'b0001, 2'd0, "chase_pre");
    expect_at(e,      4'b0001, 2'd1, "chase_entry");
    expect_at(e + 3,  4'b0001, 2'd1, "chase_hold");
    expect_at(e + 4,  4'b0010, 2'd1, "chase_s1");
    expect_at(e + 8,  4'b0100, 2'd1, "chase_s2");
    expect_at(e + 12, 4'b1000, 2'd1, "chase_s3");
    expect_at(e + 16, 4'b0001, 2'd1, "chase_wrap");
    tick(10);
    bus_if.i_Btn[1] = 1'b0;
    tick(10);

    // Two-cycle glitch on button 2 must not leave CHASE
    bus_if.i_Btn[2] = 1'b1;
    tick(2);
    bus_if.i_Btn[2] = 1'b0;
    expect_at(e + 20, 4'b0010, 2'd1, "glitch_a");
    expect_at(e + 24, 4'b0100, 2'd1, "glitch_b");
    tick(6);

    // Held button 2 enters BOUNCE
    bus_if.i_Btn[2] = 1'b1;
    p = cyc;
    expect_at(p + 5,  4'b0100, 2'd1, "bounce_pre");
    expect_at(p + 6,  4'b0001, 2'd2, "bounce_entry");
    expect_at(p + 10, 4'b0010, 2'd2, "bounce_s1");
    expect_at(p + 14, 4'b0100, 2'd2, "bounce_s2");
    expect_at(p + 18, 4'b1000, 2'd2, "bounce_s3");
    expect_at(p + 22, 4'b0100, 2'd2, "bounce_s4");
    expect_at(p + 26, 4'b0010, 2'd2, "bounce_s5");
    expect_at(p + 30, 4'b0001, 2'd2, "bounce_s6");
    expect_at(p + 34, 4'b0010, 2'd2, "bounce_s7");
    tick(8);
    bus_if.i_Btn[2] = 1'b0;
    tick(28);

    // BLINK toggling, then a re-press while dark restarts the phase
    bus_if.i_Btn[3] = 1'b1;
    q = cyc;
    expect_at(q + 6,  4'b1111, 2'd3, "blink_entry");
    expect_at(q + 10, 4'b0000, 2'd3, "blink_s1");
    expect_at(q + 14, 4'b1111, 2'd3, "blink_s2");
    expect_at(q + 18, 4'b0000, 2'd3, "blink_s3");
    tick(8);
    bus_if.i_Btn[3] = 1'b0;
    tick(6);
    bus_if.i_Btn[3] = 1'b1;
    expect_at(q + 19, 4'b0000, 2'd3, "blink_dark");
    expect_at(q + 20, 4'b1111, 2'd3, "blink_repress");
    expect_at(q + 22, 4'b1111, 2'd3, "blink_restart");
    expect_at(q + 24, 4'b0000, 2'd3, "blink_r1");
    expect_at(q + 28, 4'b1111, 2'd3, "blink_r2");
    tick(6);
    bus_if.i_Btn[3] = 1'b0;
    tick(12);

    // Simultaneous buttons 0 and 2: lowest index selects STATIC
    bus_if.i_Btn[0] = 1'b1;
    bus_if.i_Btn[2] = 1'b1;
    s = cyc;
    expect_at(s + 6,  4'b0001, 2'd0, "static_entry");
    expect_at(s + 12, 4'b0001, 2'd0, "static_hold");
    tick(8);
    bus_if.i_Btn[0] = 1'b0;
    bus_if.i_Btn[2] = 1'b0;
    tick(6);

    // Repeated STATIC presses rotate one place each, wrapping
    for (int k = 0; k < 4; k++) begin
      bus_if.i_Btn[0] = 1'b1;
      t = cyc;
      expect_at(t + 5, prev_exp[k], 2'd0, "static_prev");
      expect_at(t + 6, rot_exp[k],  2'd0, "static_rot");
      tick(8);
      bus_if.i_Btn[0] = 1'b0;
      tick(6);
    end

    // Asynchronous reset in the middle of CHASE
    bus_if.i_Btn[1] = 1'b1;
    u = cyc;
    expect_at(u + 6,  4'b0001, 2'd1, "chase2_entry");
    expect_at(u + 10, 4'b0010, 2'd1, "chase2_s1");
    tick(8);
    bus_if.i_Btn[1] = 1'b0;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_led",  32'(bus_if.o_LED),  32'h1);
    check_val("arst_mode", 32'(bus_if.o_Mode), 32'h0);
    tick(2);
    rst_n = 1'b1;
    t = cyc;
    expect_at(t + 3, 4'b0001, 2'd0, "post_rst");
    expect_at(t + 8, 4'b0001, 2'd0, "post_rst_hold");
    tick(12);

    check_val("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Button-driven LED pattern engine for the Go Board LED bank.
- Four debounced push-buttons select one of four display modes: STATIC, CHASE, BOUNCE and BLINK.
- Animated modes advance on a parametrised step tick. LED count is parametrised.
- Sits between the raw board buttons and the LED pins. Exports the current mode for other logic.

Parameters:
- NUM_LEDS, 4, number of LEDs driven; legal range 2 to 16.
- CLKS_PER_STEP, 6250000, clock cycles per animation step (4 Hz at 25 MHz); minimum 2.
- DEBOUNCE_CLKS, 250000, consecutive stable cycles needed to accept a button change (10 ms); minimum 2.

Ports:
- i_Clk  input  1  system clock.
- i_Rst_L  input  1  asynchronous active-low reset.
- i_Btn  input  4  raw asynchronous buttons, active-high.
- o_LED  output  NUM_LEDS  LED drive, registered, active-high.
- o_Mode  output  2  current mode: 0 STATIC, 1 CHASE, 2 BOUNCE, 3 BLINK.

Behaviour:
- Reset: i_Rst_L low asynchronously clears all state.
  - Outputs: o_Mode=0, o_LED=one-hot bit0.
  - Internal: step counter=0, direction=left, synchronisers=0, debounced states=0, debounce counters=0.
  - Reset mid-animation or mid-debounce abandons the operation; nothing is retained.
- Input path, per button:
  - 2-flop synchroniser.
  - Debounce counter: clears whenever the synced value equals the debounced state; otherwise increments.
  - When the count reaches DEBOUNCE_CLKS-1 while still mismatched, the debounced state takes the synced value and the counter clears.
  - Press event = debounced 0->1 transition, single-cycle internal pulse. Releases generate no event.
- Press latency: a clean raw rise held steady changes o_Mode/o_LED exactly DEBOUNCE_CLKS+3 cycles later.
- Glitches: a glitch shorter than DEBOUNCE_CLKS cycles produces no event.
- Simultaneous press events: lowest button index wins; the others are discarded.
- Press of button k when current mode != k:
  - o_Mode<=k; step counter<=0; direction<=left.
  - o_LED<=one-hot bit0 for STATIC, CHASE and BOUNCE; all-ones for BLINK.
- Press of button k when current mode == k:
  - STATIC: o_LED rotates left by one, wrapping MSB->bit0. Step counter is unused.
  - CHASE, BOUNCE, BLINK: pattern and counter restart exactly as on mode entry.
- Step tick:
  - Counter runs 0..CLKS_PER_STEP-1 and wraps, in all modes except STATIC, where it is held at 0.
  - The pattern updates on the edge where the counter equals CLKS_PER_STEP-1, so the first update comes CLKS_PER_STEP cycles after mode entry.
  - A press event in the same cycle as a step tick takes priority; the tick is dropped.
- Per-mode pattern update:
  - CHASE: rotate left by one; wraps MSB->bit0.
  - BOUNCE: shift in the current direction.
    - Direction flips to right when the new value is the MSB, and to left when it is bit0.
    - Sequence for 4 LEDs: 0001,0010,0100,1000,0100,0010,0001,0010...
    - No value repeats at the ends.
  - BLINK: invert all bits (all-ones <-> all-zeros).
- Invariant: o_LED is always exactly one-hot in STATIC, CHASE and BOUNCE.
- Arithmetic: counter widths are $clog2 of the respective parameter; no overflow is possible.

Test Plan (NUM_LEDS=4, CLKS_PER_STEP=4, DEBOUNCE_CLKS=3):
- Reset: assert i_Rst_L=0 mid-CHASE, asynchronously between clock edges -> o_LED=0001 and o_Mode=0 immediately, before the next clock edge.
- Debounce latency: raise i_Btn[1] and hold -> o_Mode=1, o_LED=0001 exactly 6 cycles after the raw rise. Then o_LED=0010, 0100, 1000, 0001 every 4 cycles.
- Glitch rejection: pulse i_Btn[2] high for 2 cycles, then low -> no mode change. Hold it high for 4+ cycles -> o_Mode=2.
- BOUNCE sequence: in BOUNCE, sample every 4 cycles -> 0010,0100,1000,0100,0010,0001,0010.
- BLINK: press Btn3 -> o_LED=1111, then 0000 after 4 cycles, then 1111.
  - Re-press Btn3 while o_LED=0000 -> o_LED=1111 and the counter restarts.
- STATIC and simultaneous presses:
  - Raise Btn0 and Btn2 in the same cycle -> o_Mode=0.
  - Three further Btn0 presses -> o_LED=0010, 0100, 1000.
  - A fourth Btn0 press -> o_LED=0001, wrapping.
